// File: rtl/mips_pkg.sv
// Shared constants and clear-sequencer state encoding for the MIPS register file.
package mips_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;
endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every index once writing zero, then parks in READY.
module regfile_clear_seq
  import mips_pkg::*;
#(
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  output logic              Busy,
  output logic [ADDR_W-1:0] ClrIdx,
  output logic              ClrWe
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ClrWe     = 1'b0;
    case (state)
      CLEAR: begin
        ClrWe   = 1'b1;
        cnt_nxt = cnt + ONE;
        // Last index written this edge; counter wraps to 0 and stays idle.
        if (cnt == '1) state_nxt = READY;
      end
      READY: ;
      default: state_nxt = CLEAR;
    endcase
  end

  assign Busy   = (state == CLEAR);
  assign ClrIdx = cnt;

endmodule

// File: rtl/mips_register_file.sv
// 32x32 MIPS GPR file: 2 combinational read ports, 1 write port, r0 hardwired to 0,
// storage cleared by a sequencer after reset so the array carries no reset.
module mips_register_file
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] RdAddrA,
  output logic [DATA_W-1:0] RdDataA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [DATA_W-1:0] RdDataB,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  output logic              Busy,
  output logic              WrDropped,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0] Debug
);

  localparam int               DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic [ADDR_W-1:0] clr_idx;
  logic              clr_we;
  logic              usr_we;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Busy   (busy),
    .ClrIdx (clr_idx),
    .ClrWe  (clr_we)
  );

  assign usr_we = WrEn && !busy && (WrAddr != ZERO_IDX);

  // Single write port muxed between clear and user so the array maps to RAM.
  always_comb begin
    we = clr_we | usr_we;
    wa = clr_we ? clr_idx : WrAddr;
    wd = clr_we ? '0      : WrData;
  end

  always_ff @(posedge Clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) WrDropped <= 1'b0;
    else        WrDropped <= WrEn && busy;
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    if (busy || a == ZERO_IDX)             return '0;
    if (BYPASS && WrEn && WrAddr == a)     return WrData;
    return mem[a];
  endfunction

  always_comb RdDataA = rd_port(RdAddrA);
  always_comb RdDataB = rd_port(RdAddrB);
  always_comb Debug   = busy ? '0 : mem[DbgAddr];

  assign Busy = busy;

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file: clear sequence, r0, bypass, dropped writes, mid-run reset.
module tb_mips_register_file;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [4:0]  RdAddrA = '0, RdAddrB = '0, WrAddr = '0, DbgAddr = '0;
  logic [31:0] RdDataA, RdDataB, WrData = '0, Debug;
  logic        WrEn = 1'b0;
  logic        Busy, WrDropped;

  int n_cmp = 0;
  int n_err = 0;

  mips_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .RdAddrA   (RdAddrA),
    .RdDataA   (RdDataA),
    .RdAddrB   (RdAddrB),
    .RdDataB   (RdDataB),
    .WrEn      (WrEn),
    .WrAddr    (WrAddr),
    .WrData    (WrData),
    .Busy      (Busy),
    .WrDropped (WrDropped),
    .DbgAddr   (DbgAddr),
    .Debug     (Debug)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with Rst_n just released; counts edges until Busy drops.
  // With inject set, a write to r3 is attempted before the 3rd edge.
  task automatic wait_clear(input bit inject);
    int cnt;
    cnt = 0;
    while (Busy && cnt < 40) begin
      WrEn   = inject && (cnt == 2);
      WrAddr = 5'd3;
      WrData = 32'h1;
      RdAddrA = 5'(cnt);
      RdAddrB = 5'(cnt + 1);
      DbgAddr = 5'(cnt);
      #1;
      if (cnt == 5) begin
        chk("busy_rdA", RdDataA, 32'h0);
        chk("busy_rdB", RdDataB, 32'h0);
        chk("busy_dbg", Debug,   32'h0);
      end
      @(posedge Clk); #1;
      cnt++;
      if (inject && (cnt == 3 || cnt == 4))
        chk($sformatf("wrdrop_e%0d", cnt), {31'b0, WrDropped}, {31'b0, cnt == 3});
      @(negedge Clk);
    end
    WrEn = 1'b0;
    chk("busy_cycles", cnt, 32);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_busy",  {31'b0, Busy},      32'h1);
    chk("rst_wrdrop",{31'b0, WrDropped}, 32'h0);
    chk("rst_rdA",   RdDataA,            32'h0);

    // 1: clear sequence, then everything reads 0
    @(negedge Clk); Rst_n = 1'b1;
    wait_clear(1'b0);
    for (int i = 0; i < 32; i++) begin
      RdAddrA = 5'(i); RdAddrB = 5'(31 - i); DbgAddr = 5'(i);
      #1;
      chk($sformatf("clr_A%0d", i), RdDataA, 32'h0);
      chk($sformatf("clr_B%0d", 31 - i), RdDataB, 32'h0);
      chk($sformatf("clr_D%0d", i), Debug, 32'h0);
    end

    // 2: write r5, read next cycle on both ports and debug
    @(negedge Clk);
    WrEn = 1'b1; WrAddr = 5'd5; WrData = 32'hDEADBEEF;
    @(negedge Clk);
    WrEn = 1'b0; RdAddrA = 5'd5; RdAddrB = 5'd5; DbgAddr = 5'd5;
    #1;
    chk("r5_A",   RdDataA, 32'hDEADBEEF);
    chk("r5_B",   RdDataB, 32'hDEADBEEF);
    chk("r5_dbg", Debug,   32'hDEADBEEF);

    // 3: r0 write ignored, no dropped pulse
    @(negedge Clk);
    WrEn = 1'b1; WrAddr = 5'd0; WrData = 32'h12345678; RdAddrA = 5'd0;
    #1;
    chk("r0_samecyc", RdDataA, 32'h0);
    @(negedge Clk);
    WrEn = 1'b0; DbgAddr = 5'd0;
    #1;
    chk("r0_A",      RdDataA, 32'h0);
    chk("r0_dbg",    Debug,   32'h0);
    chk("r0_wrdrop", {31'b0, WrDropped}, 32'h0);

    // 4: same-cycle bypass on r7, debug shows old contents until the edge
    @(negedge Clk);
    WrEn = 1'b1; WrAddr = 5'd7; WrData = 32'hCAFEF00D;
    RdAddrA = 5'd7; RdAddrB = 5'd7; DbgAddr = 5'd7;
    #1;
    chk("byp_A",   RdDataA, 32'hCAFEF00D);
    chk("byp_B",   RdDataB, 32'hCAFEF00D);
    chk("byp_dbg", Debug,   32'h0);
    @(negedge Clk);
    WrEn = 1'b0; RdAddrB = 5'd5;
    #1;
    chk("r7_dbg", Debug,   32'hCAFEF00D);
    chk("r7_A",   RdDataA, 32'hCAFEF00D);
    chk("r5_B2",  RdDataB, 32'hDEADBEEF);

    // 6 (+5): write r9, reset mid-run, dropped write to r3 during clear
    @(negedge Clk);
    WrEn = 1'b1; WrAddr = 5'd9; WrData = 32'hA5A5A5A5;
    @(negedge Clk);
    WrEn = 1'b0; RdAddrA = 5'd9;
    #1;
    chk("r9_A", RdDataA, 32'hA5A5A5A5);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk("rst2_busy",   {31'b0, Busy},      32'h1);
    chk("rst2_wrdrop", {31'b0, WrDropped}, 32'h0);
    chk("rst2_rdA",    RdDataA,            32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    wait_clear(1'b1);
    RdAddrA = 5'd9; RdAddrB = 5'd3; DbgAddr = 5'd5;
    #1;
    chk("r9_after", RdDataA, 32'h0);
    chk("r3_after", RdDataB, 32'h0);
    chk("r5_after", Debug,   32'h0);
    chk("ready_wrdrop", {31'b0, WrDropped}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
